// File: rtl/digit_display_driver.sv
// Holds the two irrigation-mode digits in set/clear-dominant registers and
// scans them onto a shared common-anode 7-segment bus with dead-time blanking.
module digit_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A0SET,
  input  logic       A0Clear,
  input  logic       B0SET,
  input  logic       B0Clear,
  input  logic       A1SET,
  input  logic       A1Clear,
  input  logic       B1SET,
  input  logic       B1Clear,
  input  logic       C1SET,
  input  logic       C1Clear,
  input  logic       D1SET,
  input  logic       D1Clear,
  output logic [1:0] digit0,
  output logic [3:0] digit1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       changed
);

  // state      | meaning
  // SLOT0_DEAD | digit 0 slot, anodes off (blanking)
  // SLOT0_ON   | digit 0 driven, an = 10
  // SLOT1_DEAD | digit 1 slot, anodes off (blanking)
  // SLOT1_ON   | digit 1 driven, an = 01

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {SLOT0_DEAD, SLOT0_ON, SLOT1_DEAD, SLOT1_ON} scanState_t;

  scanState_t    scanState, scanStateNext;
  logic [CW-1:0] refreshCnt, refreshCntNext;
  logic [1:0]    digit0Next;
  logic [3:0]    digit1Next;

  function automatic logic [6:0] decodeSeg(input logic [3:0] value);
    case (value)
      4'd0:    decodeSeg = 7'b1000000;
      4'd1:    decodeSeg = 7'b1111001;
      4'd2:    decodeSeg = 7'b0100100;
      4'd3:    decodeSeg = 7'b0110000;
      4'd4:    decodeSeg = 7'b0011001;
      4'd5:    decodeSeg = 7'b0010010;
      4'd6:    decodeSeg = 7'b0000010;
      4'd7:    decodeSeg = 7'b1111000;
      4'd8:    decodeSeg = 7'b0000000;
      4'd9:    decodeSeg = 7'b0010000;
      default: decodeSeg = 7'b0000110;
    endcase
  endfunction

  // SET wins over Clear when both strobes arrive together.
  always_comb begin
    digit0Next = {B0SET, A0SET} | (digit0 & ~{B0Clear, A0Clear});
    digit1Next = {D1SET, C1SET, B1SET, A1SET}
               | (digit1 & ~{D1Clear, C1Clear, B1Clear, A1Clear});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit0  <= '0;
      digit1  <= '0;
      changed <= 1'b0;
    end else begin
      digit0  <= digit0Next;
      digit1  <= digit1Next;
      changed <= ({digit1Next, digit0Next} != {digit1, digit0});
    end
  end

  always_comb begin
    refreshCntNext = (refreshCnt == CW'(REFRESH_DIV - 1)) ? '0 : refreshCnt + CW'(1);
    scanStateNext  = scanState;
    if (refreshCnt == CW'(REFRESH_DIV - 1)) begin
      scanStateNext = (scanState == SLOT0_ON || scanState == SLOT0_DEAD) ? SLOT1_DEAD : SLOT0_DEAD;
    end else if (refreshCntNext == CW'(DEAD_CYCLES)) begin
      case (scanState)
        SLOT0_DEAD: scanStateNext = SLOT0_ON;
        SLOT1_DEAD: scanStateNext = SLOT1_ON;
        default:    scanStateNext = scanState;
      endcase
    end
  end

  // Outputs are registered from the next state so an/seg line up with the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanState  <= SLOT0_DEAD;
      refreshCnt <= '0;
      an         <= 2'b11;
      seg        <= 7'b1111111;
    end else begin
      scanState  <= scanStateNext;
      refreshCnt <= refreshCntNext;
      case (scanStateNext)
        SLOT0_ON: begin
          an  <= 2'b10;
          seg <= decodeSeg({2'b00, digit0});
        end
        SLOT1_ON: begin
          an  <= 2'b01;
          seg <= decodeSeg(digit1);
        end
        default: begin
          an  <= 2'b11;
          seg <= 7'b1111111;
        end
      endcase
    end
  end

endmodule
